// File: rtl/pipe_flopenrc_pkg.sv
// Shared types and helpers for the elastic pipeline register and the CPU hazard unit.
package pipe_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Hazard-unit control bundle: stall maps onto !out_ready, flush feeds the block directly.
  typedef struct packed {
    logic stall;
    logic flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/pipe_flopenrc_if.sv
// Valid/ready handshake bundle for the elastic pipeline register, plus its occupancy count.
interface pipe_flopenrc_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) ();

  localparam int CW = cnt_w(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/pipe_flopenrc_stage.sv
// One pipeline stage: a valid flop and an enable-gated data register, both synchronously clearable.
module pipe_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // A bubble moving in clears valid but leaves data untouched to keep toggling low.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (load) begin
      valid <= in_valid;
      if (in_valid) data <= in_data;
    end
  end

endmodule

// File: rtl/pipe_flopenrc.sv
// Elastic, stallable, flushable pipeline register built from DEPTH bubble-collapsing stages.
module pipe_flopenrc
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  pipe_flopenrc_if.slave bus
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH:0]   ready;
  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [CW-1:0]    count_c;

  // A stage can load when it is empty or anything downstream can move.
  always_comb begin
    ready        = '0;
    ready[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) ready[i] = !valid_q[i] || ready[i+1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    if (i == 0) begin : g_head
      assign src_valid = bus.in_valid;
      assign src_data  = bus.in_data;
    end else begin : g_body
      assign src_valid = valid_q[i-1];
      assign src_data  = data_q[i-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .clear    (flush),
      .load     (ready[i]),
      .in_valid (src_valid),
      .in_data  (src_data),
      .valid    (valid_q[i]),
      .data     (data_q[i])
    );
  end

  // Occupancy is derived from registered valids only, so it has no input-to-output path.
  always_comb begin
    count_c = '0;
    for (int i = 0; i < DEPTH; i++) count_c = count_c + CW'(valid_q[i]);
  end

  assign bus.in_ready  = ready[0] && !flush;
  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.count     = count_c;

endmodule
